chunk_scheduler: RTL and testbench

CHUNK_SCHEDULER -- requirements
Module: chunk_scheduler

---
 rtl/chunk_scheduler_if.sv | 45 ++++
 rtl/chunk_scheduler.sv | 169 ++++++++++++++++
 tb/tb_chunk_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_scheduler_if.sv
// rtl/chunk_scheduler_if.sv - bank write/read handshake bundle between the chunk scheduler and its neighbours
interface chunk_scheduler_if #(
    parameter int WR_CYC_NUM = 4,
    parameter int SM_NUM     = 8
);
    localparam int WC_W = $clog2(WR_CYC_NUM);
    localparam int SM_W = (SM_NUM > 1) ? $clog2(SM_NUM) : 1;

    logic            in_valid_i;
    logic            in_ready_o;
    logic            ifm_wr_valid_o;
    logic            filter_wr_valid_o;
    logic [WC_W-1:0] wr_count_o;
    logic            wr_sel_o;
    logic            rd_sel_o;
    logic            chunk_start_o;
    logic [SM_W-1:0] rd_sparsemap_last_o;
    logic            chunk_end_i;

    modport master (
        input  in_valid_i,
        input  chunk_end_i,
        output in_ready_o,
        output ifm_wr_valid_o,
        output filter_wr_valid_o,
        output wr_count_o,
        output wr_sel_o,
        output rd_sel_o,
        output chunk_start_o,
        output rd_sparsemap_last_o
    );

    modport slave (
        output in_valid_i,
        output chunk_end_i,
        input  in_ready_o,
        input  ifm_wr_valid_o,
        input  filter_wr_valid_o,
        input  wr_count_o,
        input  wr_sel_o,
        input  rd_sel_o,
        input  chunk_start_o,
        input  rd_sparsemap_last_o
    );
endinterface

// File: rtl/chunk_scheduler.sv
// rtl/chunk_scheduler.sv - ping-pong bank scheduler: fills two banks from upstream beats and hands full banks to the reader
module chunk_scheduler #(
    parameter int WR_CYC_NUM = 4,
    parameter int SM_NUM     = 8,
    parameter int CNT_W      = 16,
    localparam int SM_W      = (SM_NUM > 1) ? $clog2(SM_NUM) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] chunk_total_i,
    input  logic [SM_W-1:0]  sm_last_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] chunk_idx_o,
    chunk_scheduler_if.master sched_if
);
    localparam int WC_W = $clog2(WR_CYC_NUM);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic [WC_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0] written_q, written_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [SM_W-1:0]  sm_last_q, sm_last_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;

    logic busy;
    logic in_ready;
    logic beat_acc;
    logic fill_set;
    logic release_c;
    logic last_chunk;

    assign busy       = (state_q == ST_WAIT) | (state_q == ST_START) | (state_q == ST_RUN);
    assign in_ready   = busy & ~bank_full_q[wr_sel_q] & (written_q < total_q) & ~abort_i;
    assign beat_acc   = sched_if.in_valid_i & in_ready;
    assign fill_set   = beat_acc & (beat_q == WC_W'(WR_CYC_NUM - 1));
    // chunk_end_i idles high from the input selector, so it only counts while a chunk is handed out
    assign release_c  = ((state_q == ST_START) | (state_q == ST_RUN)) & sched_if.chunk_end_i;
    assign last_chunk = (idx_q == total_q - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        bank_full_d = bank_full_q;
        beat_d      = beat_q;
        written_d   = written_q;
        idx_d       = idx_q;
        total_d     = total_q;
        sm_last_d   = sm_last_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;

        if (beat_acc) begin
            if (fill_set) begin
                beat_d                = '0;
                bank_full_d[wr_sel_q] = 1'b1;
                wr_sel_d              = ~wr_sel_q;
                written_d             = written_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + WC_W'(1);
            end
        end

        // a fill and a release never target the same bank, so both edits apply together
        if (release_c) begin
            bank_full_d[rd_sel_q] = 1'b0;
            rd_sel_d              = ~rd_sel_q;
            idx_d                 = idx_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    total_d     = chunk_total_i;
                    sm_last_d   = sm_last_i;
                    bank_full_d = '0;
                    beat_d      = '0;
                    written_d   = '0;
                    idx_d       = '0;
                    wr_sel_d    = 1'b0;
                    rd_sel_d    = 1'b0;
                    state_d     = (chunk_total_i != '0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (bank_full_q[rd_sel_q]) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (release_c) begin
                    state_d = last_chunk ? ST_DONE : ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (release_c) begin
                    state_d = last_chunk ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d     = ST_IDLE;
            bank_full_d = '0;
            beat_d      = '0;
            written_d   = '0;
            idx_d       = '0;
            wr_sel_d    = 1'b0;
            rd_sel_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bank_full_q <= '0;
            beat_q      <= '0;
            written_q   <= '0;
            idx_q       <= '0;
            total_q     <= '0;
            sm_last_q   <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            beat_q      <= beat_d;
            written_q   <= written_d;
            idx_q       <= idx_d;
            total_q     <= total_d;
            sm_last_q   <= sm_last_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fill_set && release_c && (wr_sel_q == rd_sel_q)));

    assign busy_o                       = busy;
    assign done_o                       = (state_q == ST_DONE) & ~abort_i;
    assign chunk_idx_o                  = idx_q;
    assign sched_if.in_ready_o          = in_ready;
    assign sched_if.ifm_wr_valid_o      = beat_acc;
    assign sched_if.filter_wr_valid_o   = beat_acc;
    assign sched_if.wr_count_o          = beat_q;
    assign sched_if.wr_sel_o            = wr_sel_q;
    assign sched_if.rd_sel_o            = rd_sel_q;
    assign sched_if.chunk_start_o       = (state_q == ST_START);
    assign sched_if.rd_sparsemap_last_o = sm_last_q;
endmodule

// File: tb/tb_chunk_scheduler.sv
// tb/tb_chunk_scheduler.sv - scoreboard bench for chunk_scheduler with randomized jobs and a job-level reference model
module tb_chunk_scheduler;
    localparam int W   = 4;
    localparam int SMN = 8;
    localparam int CW  = 16;
    localparam int SMW = 3;
    localparam int WCW = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] total = '0;
    logic [SMW-1:0] sm   = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] cidx;

    chunk_scheduler_if #(.WR_CYC_NUM(W), .SM_NUM(SMN)) bus ();

    chunk_scheduler #(.WR_CYC_NUM(W), .SM_NUM(SMN), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .chunk_total_i(total),
        .sm_last_i    (sm),
        .busy_o       (busy),
        .done_o       (done),
        .chunk_idx_o  (cidx),
        .sched_if     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // expected streams, pushed by the stimulus side only; the monitor walks them with its own read pointers
    int exp_beat[$];
    int exp_chunk[$];
    int exp_done_total = 0;
    int beat_rd = 0;
    int chunk_rd = 0;
    int done_rd = 0;

    int beats_seen = 0;
    int cs_cnt = 0;
    int done_cnt = 0;
    int last_fill_cyc = 0;
    int end_cyc = 0;
    int e;

    int valid_pct = 0;
    int end_delay = 10;
    bit end_hold = 1'b0;
    bit lat_chk = 1'b0;
    bit done_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // upstream beat source
    initial begin
        bus.in_valid_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.in_valid_i = ($urandom_range(99) < valid_pct);
        end
    end

    // input selector model: either holds chunk_end high, or pulses it end_delay cycles after chunk_start
    initial begin
        logic seen;
        logic ab;
        int   cnt;
        cnt = 0;
        bus.chunk_end_i = 1'b0;
        forever begin
            @(negedge clk);
            seen = bus.chunk_start_o;
            ab   = abort | ~rst_n;
            @(posedge clk);
            #1;
            if (end_hold) begin
                bus.chunk_end_i = 1'b1;
            end else begin
                bus.chunk_end_i = 1'b0;
                if (ab) begin
                    cnt = 0;
                end else if (seen) begin
                    cnt = end_delay - 1;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.chunk_end_i = 1'b1;
                        end_cyc = cyc;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n || abort) begin
            beat_rd  = exp_beat.size();
            chunk_rd = exp_chunk.size();
            done_rd  = exp_done_total;
        end else begin
            if (bus.ifm_wr_valid_o) begin
                chk("filter_follows_ifm", 64'(bus.filter_wr_valid_o), 64'(1));
                if (beat_rd >= exp_beat.size()) begin
                    chk("beat_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_beat[beat_rd];
                    beat_rd++;
                    chk("beat_sel_count", 64'(int'(bus.wr_sel_o) * 16 + int'(bus.wr_count_o)), 64'(e));
                end
                beats_seen++;
                if (bus.wr_count_o == WCW'(W - 1)) last_fill_cyc = cyc;
            end else begin
                chk("filter_wr_valid_low", 64'(bus.filter_wr_valid_o), 64'(0));
            end
            if (bus.chunk_start_o) begin
                chk("busy_at_start", 64'(busy), 64'(1));
                if (chunk_rd >= exp_chunk.size()) begin
                    chk("chunk_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_chunk[chunk_rd];
                    chunk_rd++;
                    chk("chunk_idx_sel_sm", 64'(int'(cidx) * 256 + int'(bus.rd_sel_o) * 16
                        + int'(bus.rd_sparsemap_last_o)), 64'(e));
                end
                cs_cnt++;
                if (lat_chk) chk("start_latency", 64'(cyc - last_fill_cyc), 64'(2));
            end
            if (done) begin
                chk("busy_in_done", 64'(busy), 64'(0));
                if (done_rd >= exp_done_total) begin
                    chk("done_unexpected", 64'(1), 64'(0));
                end else begin
                    done_rd++;
                end
                done_cnt++;
                if (done_chk) chk("done_latency", 64'(cyc - end_cyc), 64'(1));
            end
        end
    end

    // reference model: beat n of a job lands in bank (n/W)%2 at index n%W, chunk k is read from bank k%2
    task automatic start_job(input int t, input int s);
        for (int n = 0; n < t * W; n++) exp_beat.push_back(((n / W) % 2) * 16 + (n % W));
        for (int k = 0; k < t; k++) exp_chunk.push_back(k * 256 + (k % 2) * 16 + s);
        exp_done_total++;
        @(posedge clk);
        #1;
        total = CW'(t);
        sm    = SMW'(s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < maxc) begin
            @(negedge clk);
            i++;
        end
        chk(name, 64'(done_cnt - d0), 64'(1));
        @(negedge clk);
        chk("idle_after_done", 64'(busy), 64'(0));
        chk("beats_left", 64'(exp_beat.size() - beat_rd), 64'(0));
        chk("chunks_left", 64'(exp_chunk.size() - chunk_rd), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int b0;
        int i;
        int t;
        int s;

        valid_pct = 100;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'(0));
        chk("rst_wr_valid", 64'({bus.ifm_wr_valid_o, bus.filter_wr_valid_o}), 64'(0));
        chk("rst_chunk_start", 64'(bus.chunk_start_o), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sm_last", 64'(bus.rd_sparsemap_last_o), 64'(0));
        chk("rst_wr_count", 64'(bus.wr_count_o), 64'(0));
        chk("rst_sels", 64'({bus.wr_sel_o, bus.rd_sel_o}), 64'(0));
        chk("rst_chunk_idx", 64'(cidx), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single chunk, held valid, fixed reader delay
        lat_chk  = 1'b1;
        done_chk = 1'b1;
        end_delay = 10;
        start_job(1, 5);
        wait_done("t1_done", 200);
        lat_chk = 1'b0;

        // both banks fill while the reader is slow
        end_delay = 20;
        start_job(4, 2);
        repeat (16) @(negedge clk);
        chk("t2_ready_blocked", 64'(bus.in_ready_o), 64'(0));
        chk("t2_both_full_sels", 64'({bus.wr_sel_o, bus.rd_sel_o}), 64'(0));
        chk("t2_busy", 64'(busy), 64'(1));
        wait_done("t2_done", 1000);

        // chunk_end held high: ignored in IDLE/WAIT, releases straight from START
        done_chk = 1'b0;
        end_hold = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3_idle_idx", 64'(cidx), 64'(4));
        valid_pct = 0;
        start_job(3, 0);
        repeat (6) @(negedge clk);
        chk("t3_wait_idx", 64'(cidx), 64'(0));
        chk("t3_wait_busy", 64'(busy), 64'(1));
        valid_pct = 60;
        wait_done("t3_done", 1000);
        start_job(0, 1);
        wait_done("t3_zero_done", 20);

        // abort in RUN of chunk 2, then a fresh job
        end_hold  = 1'b0;
        done_chk  = 1'b1;
        end_delay = 8;
        valid_pct = 100;
        c0 = cs_cnt;
        start_job(4, 3);
        i = 0;
        while (cs_cnt - c0 < 3 && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("t4_reach_chunk2", 64'(cs_cnt - c0), 64'(3));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_busy", 64'(busy), 64'(0));
        chk("t4_abort_sels", 64'({bus.wr_sel_o, bus.rd_sel_o}), 64'(0));
        chk("t4_abort_idx", 64'(cidx), 64'(0));
        chk("t4_abort_count", 64'(bus.wr_count_o), 64'(0));
        chk("t4_abort_done", 64'(done), 64'(0));
        repeat (5) @(negedge clk);
        start_job(2, 6);
        wait_done("t4_restart_done", 500);

        // asynchronous reset partway through filling bank 0
        b0 = beats_seen;
        start_job(2, 4);
        i = 0;
        while (beats_seen - b0 < 3 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("t5_reach_beat2", 64'(beats_seen - b0 >= 3), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 64'(bus.in_ready_o), 64'(0));
        chk("t5_rst_wr_valid", 64'({bus.ifm_wr_valid_o, bus.filter_wr_valid_o}), 64'(0));
        chk("t5_rst_count", 64'(bus.wr_count_o), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_start_done", 64'({bus.chunk_start_o, done}), 64'(0));
        chk("t5_rst_sm_last", 64'(bus.rd_sparsemap_last_o), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_job(2, 4);
        wait_done("t5_new_job_done", 500);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            t = int'($urandom_range(1, 5));
            s = int'($urandom_range(0, 7));
            valid_pct = int'($urandom_range(30, 100));
            end_hold  = ($urandom_range(3) == 0);
            end_delay = int'($urandom_range(2, 12));
            done_chk  = !end_hold;
            start_job(t, s);
            wait_done("rand_done", 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
